execute_forward_unit: RTL and testbench

//  Parametrised execute-stage control: holds the EX-stage copy of decoded operand fields, picks per-operand

---
 rtl/execute_forward_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_execute_forward_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/execute_forward_unit.sv
// -----------------------------------------------------------------------------
// execute_forward_unit
//
// Execute-stage control for the operand datapath. It keeps the EX-stage copy of
// the decoded operand fields and picks a forwarding source for each of the three
// operands (A = Rn, B = Rm, S = Rs). It also detects load-use hazards against
// the nearest downstream stage and requests stalls. On a stall or a branch flush
// it presents a bubble to the datapath.
//
// Parameters
//   NUM_FWD  : number of downstream forwarding sources (0 = memory, 1 = wb, ...)
//   RADDR_W  : register index width
//   PC_REG   : register index that always reads the PC and is never forwarded
//   LOAD_LAT : total stall cycles inserted on a load-use hazard (1..7)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   dec_valid                decode presents an instruction
//   dec_rn/rm/rs             source register indices
//   dec_use                  {use_rs, use_rm, use_rn} operand-read flags
//   dec_rd, dec_is_load      destination index and load flag, passed down
//   flush                    kill the EX contents (branch taken / mispredict)
//   fwd_valid[k]             source k holds a live register write
//   fwd_rd[k*RADDR_W +: ..]  destination register of source k
//   fwd_pending[k]           data of source k is not available yet
//   sel_A/B/S                0 = regfile, k+1 = forward source k, NUM_FWD+1 = PC
//   en_A/B/S                 operand register load enables
//   ex_valid                 EX holds a live, non-stalled instruction
//   ex_rd, ex_is_load        destination and load flag of the EX instruction
//   stall_req                hold fetch/decode this cycle
// -----------------------------------------------------------------------------
module execute_forward_unit #(
  parameter int NUM_FWD  = 2,
  parameter int RADDR_W  = 4,
  parameter int PC_REG   = 15,
  parameter int LOAD_LAT = 1,
  localparam int SEL_W   = $clog2(NUM_FWD + 2)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dec_valid,
  input  logic [RADDR_W-1:0]         dec_rn,
  input  logic [RADDR_W-1:0]         dec_rm,
  input  logic [RADDR_W-1:0]         dec_rs,
  input  logic [2:0]                 dec_use,
  input  logic [RADDR_W-1:0]         dec_rd,
  input  logic                       dec_is_load,
  input  logic                       flush,
  input  logic [NUM_FWD-1:0]         fwd_valid,
  input  logic [NUM_FWD*RADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]         fwd_pending,
  output logic [SEL_W-1:0]           sel_A,
  output logic [SEL_W-1:0]           sel_B,
  output logic [SEL_W-1:0]           sel_S,
  output logic                       en_A,
  output logic                       en_B,
  output logic                       en_S,
  output logic                       ex_valid,
  output logic [RADDR_W-1:0]         ex_rd,
  output logic                       ex_is_load,
  output logic                       stall_req
);

  localparam logic [RADDR_W-1:0] PC_IDX  = RADDR_W'(PC_REG);
  localparam logic [SEL_W-1:0]   SEL_PC  = SEL_W'(NUM_FWD + 1);
  localparam logic [SEL_W-1:0]   SEL_SRC0 = SEL_W'(1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  // EX-stage copy of the decoded instruction
  logic               valid_q, valid_d;
  logic [RADDR_W-1:0] rn_q, rn_d;
  logic [RADDR_W-1:0] rm_q, rm_d;
  logic [RADDR_W-1:0] rs_q, rs_d;
  logic [2:0]         use_q, use_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic               is_load_q, is_load_d;

  // Live EX instruction; forced low while reset is held so every output is 0.
  logic live;
  assign live = valid_q && !rst;

  // Operand indices packed in {rs, rm, rn} order to line up with use_q bits.
  logic [3*RADDR_W-1:0] src_idx;
  assign src_idx = {rs_q, rm_q, rn_q};

  // ---------------------------------------------------------------------------
  // Per-operand source selection and load-use detection
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : gen_op
      logic [RADDR_W-1:0] idx;
      logic [SEL_W-1:0]   sel;
      logic               hit_pending0;
      logic               en;

      assign idx = src_idx[gi*RADDR_W +: RADDR_W];

      always_comb begin
        sel = '0;
        if (live && use_q[gi]) begin
          if (idx == PC_IDX) begin
            sel = SEL_PC;
          end else begin
            // Walk from oldest to youngest so the lowest matching index wins.
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
              if (fwd_valid[k] && (fwd_rd[k*RADDR_W +: RADDR_W] == idx)) begin
                sel = SEL_W'(k + 1);
              end
            end
          end
        end
      end

      // Only the nearest source can still be waiting on load data; an older
      // pending source is covered by the datapath and never stalls.
      assign hit_pending0 = (sel == SEL_SRC0) && fwd_pending[0];
      assign en           = live && use_q[gi] && !stall_req;
    end
  endgenerate

  assign sel_A = gen_op[0].sel;
  assign sel_B = gen_op[1].sel;
  assign sel_S = gen_op[2].sel;
  assign en_A  = gen_op[0].en;
  assign en_B  = gen_op[1].en;
  assign en_S  = gen_op[2].en;

  logic hazard;
  assign hazard = (state_q == ST_RUN) &&
                  (gen_op[0].hit_pending0 || gen_op[1].hit_pending0 || gen_op[2].hit_pending0);

  // ---------------------------------------------------------------------------
  // Stall FSM
  //   The RUN cycle that detects the hazard is itself the first stall cycle, so
  //   the STALL state covers the remaining LOAD_LAT-1 cycles. cnt holds the
  //   number of stall cycles still to come including the current one.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_req = 1'b0;
    if (rst) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (flush) begin
      // Flush dominates: the EX instruction dies, so nothing is worth stalling for.
      state_d = ST_RUN;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (hazard) begin
            stall_req = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = ST_STALL;
              cnt_d   = 3'(LOAD_LAT - 1);
            end
          end
        end
        ST_STALL: begin
          stall_req = 1'b1;
          if (cnt_q <= 3'd1) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // EX register next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d   = valid_q;
    rn_d      = rn_q;
    rm_d      = rm_q;
    rs_d      = rs_q;
    use_d     = use_q;
    rd_d      = rd_q;
    is_load_d = is_load_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall_req) begin
      valid_d   = dec_valid;
      rn_d      = dec_rn;
      rm_d      = dec_rm;
      rs_d      = dec_rs;
      use_d     = dec_use;
      rd_d      = dec_rd;
      is_load_d = dec_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      rn_q      <= '0;
      rm_q      <= '0;
      rs_q      <= '0;
      use_q     <= '0;
      rd_q      <= '0;
      is_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      rn_q      <= rn_d;
      rm_q      <= rm_d;
      rs_q      <= rs_d;
      use_q     <= use_d;
      rd_q      <= rd_d;
      is_load_q <= is_load_d;
    end
  end

  // A stalled instruction is shown downstream as a bubble.
  assign ex_valid   = live && !stall_req;
  assign ex_rd      = rd_q;
  assign ex_is_load = is_load_q;

endmodule

// File: tb/tb_execute_forward_unit.sv
// Directed bench for execute_forward_unit with NUM_FWD=2, LOAD_LAT=2.
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns later.
module tb_execute_forward_unit;

  localparam int NUM_FWD = 2;
  localparam int RADDR_W = 4;
  localparam int SEL_W   = $clog2(NUM_FWD + 2);

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       dec_valid;
  logic [RADDR_W-1:0]         dec_rn, dec_rm, dec_rs, dec_rd;
  logic [2:0]                 dec_use;
  logic                       dec_is_load;
  logic                       flush;
  logic [NUM_FWD-1:0]         fwd_valid;
  logic [NUM_FWD*RADDR_W-1:0] fwd_rd;
  logic [NUM_FWD-1:0]         fwd_pending;
  logic [SEL_W-1:0]           sel_A, sel_B, sel_S;
  logic                       en_A, en_B, en_S;
  logic                       ex_valid, ex_is_load, stall_req;
  logic [RADDR_W-1:0]         ex_rd;

  int n_checks = 0;
  int n_pass   = 0;

  execute_forward_unit #(
    .NUM_FWD (NUM_FWD),
    .RADDR_W (RADDR_W),
    .PC_REG  (15),
    .LOAD_LAT(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dec_valid  (dec_valid),
    .dec_rn     (dec_rn),
    .dec_rm     (dec_rm),
    .dec_rs     (dec_rs),
    .dec_use    (dec_use),
    .dec_rd     (dec_rd),
    .dec_is_load(dec_is_load),
    .flush      (flush),
    .fwd_valid  (fwd_valid),
    .fwd_rd     (fwd_rd),
    .fwd_pending(fwd_pending),
    .sel_A      (sel_A),
    .sel_B      (sel_B),
    .sel_S      (sel_S),
    .en_A       (en_A),
    .en_B       (en_B),
    .en_S       (en_S),
    .ex_valid   (ex_valid),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .stall_req  (stall_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
      $display("ok   %-14s got %0d", tag, got);
    end else begin
      $display("FAIL %-14s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input int rn, input int rm, input int rs,
                         input logic [2:0] u, input int rd, input logic ld);
    dec_valid   = v;
    dec_rn      = RADDR_W'(rn);
    dec_rm      = RADDR_W'(rm);
    dec_rs      = RADDR_W'(rs);
    dec_use     = u;
    dec_rd      = RADDR_W'(rd);
    dec_is_load = ld;
  endtask

  // rd1 is source 1 (writeback), rd0 is source 0 (memory)
  task automatic set_fwd(input logic [1:0] v, input int rd1, input int rd0,
                         input logic [1:0] pend);
    fwd_valid   = v;
    fwd_rd      = {RADDR_W'(rd1), RADDR_W'(rd0)};
    fwd_pending = pend;
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    set_dec(1'b1, 3, 0, 0, 3'b001, 7, 1'b0);
    set_fwd(2'b00, 0, 0, 2'b00);

    // 1. reset held two cycles with decode valid
    tick();
    check("rst1_valid", ex_valid, 0);
    check("rst1_stall", stall_req, 0);
    tick();
    check("rst2_valid", ex_valid, 0);
    check("rst2_enA", en_A, 0);
    check("rst2_rd", ex_rd, 0);
    rst = 1'b0;
    tick();
    #1;
    check("cap_valid", ex_valid, 1);
    check("cap_rd", ex_rd, 7);
    check("cap_selA_rf", sel_A, 0);

    // 2. nearest of two matching sources wins
    set_fwd(2'b11, 3, 3, 2'b00);
    #1;
    check("near_selA", sel_A, 1);
    check("near_enA", en_A, 1);
    check("near_enB", en_B, 0);

    // 3. only source 1 matches Rm; Rn is the PC
    set_dec(1'b1, 15, 5, 0, 3'b011, 9, 1'b1);
    tick();
    set_fwd(2'b10, 5, 9, 2'b00);
    #1;
    check("pc_selA", sel_A, 3);
    check("far_selB", sel_B, 2);
    check("far_enB", en_B, 1);
    check("far_selS", sel_S, 0);
    check("far_isload", ex_is_load, 1);

    // 4. load-use hazard: two stall cycles, EX held, then source 1 forwards
    set_dec(1'b1, 4, 0, 0, 3'b001, 2, 1'b0);
    tick();
    set_dec(1'b1, 6, 0, 0, 3'b001, 8, 1'b0);
    set_fwd(2'b01, 0, 4, 2'b01);
    #1;
    check("lu0_stall", stall_req, 1);
    check("lu0_valid", ex_valid, 0);
    check("lu0_enA", en_A, 0);
    tick();
    check("lu1_stall", stall_req, 1);
    check("lu1_valid", ex_valid, 0);
    check("lu1_rd_held", ex_rd, 2);
    tick();
    set_fwd(2'b10, 4, 0, 2'b00);
    #1;
    check("lu2_stall", stall_req, 0);
    check("lu2_selA", sel_A, 2);
    check("lu2_enA", en_A, 1);
    check("lu2_rd", ex_rd, 2);

    // 5. flush against a hazard, then flush during a stall
    set_dec(1'b1, 4, 0, 0, 3'b001, 3, 1'b1);
    tick();
    set_fwd(2'b01, 0, 4, 2'b01);
    flush = 1'b1;
    #1;
    check("fl_hz_stall", stall_req, 0);
    tick();
    flush = 1'b0;
    #1;
    check("fl_next_valid", ex_valid, 0);
    check("fl_next_stall", stall_req, 0);
    tick();
    check("fl_hz2_stall", stall_req, 1);
    tick();
    flush = 1'b1;
    #1;
    check("fl_st_stall", stall_req, 0);
    tick();
    flush = 1'b0;
    #1;
    check("fl_run_stall", stall_req, 0);
    check("fl_run_valid", ex_valid, 0);

    // reset while stalled
    tick();
    check("rs_hz_stall", stall_req, 1);
    tick();
    rst = 1'b1;
    #1;
    check("rs_in_stall", stall_req, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rs_out_stall", stall_req, 0);
    check("rs_out_valid", ex_valid, 0);

    // 6. use bits clear; pending on source 1 only
    set_dec(1'b1, 4, 4, 4, 3'b000, 5, 1'b0);
    tick();
    check("nouse_selA", sel_A, 0);
    check("nouse_enA", en_A, 0);
    check("nouse_stall", stall_req, 0);
    check("nouse_valid", ex_valid, 1);
    set_dec(1'b1, 4, 0, 4, 3'b101, 6, 1'b0);
    tick();
    set_fwd(2'b10, 4, 0, 2'b10);
    #1;
    check("p1_stall", stall_req, 0);
    check("p1_selA", sel_A, 2);
    check("p1_enA", en_A, 1);
    check("p1_selS", sel_S, 2);
    check("p1_enS", en_S, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
